ram_sp_param: RTL and testbench
===============================

Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM; next generation of the lab 8x6 RAM block.
- Adds a parametrised width and depth, a ready handshake and a hardware clear sequencer that zeroes every word after reset or on request.
- Adds registered read-valid and address-error flags.
- Sits between a lab datapath/controller and its scratch storage.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 6, address port width.
- DEPTH, 64, number of implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH; an elaboration-time check fails otherwise.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  one-cycle pulse; starts a full memory clear.
- cs  in  1  chip select; request strobe.
- rw  in  1  1 = write, 0 = read.
- address  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- ready  out  1  block can accept a request this cycle.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out carries fresh read data this cycle.
- addr_err  out  1  the accepted access had address >= DEPTH.
- parity_err  out  1  read-data parity mismatch (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=INIT, clear counter=0.
  - ready, rd_valid, addr_err, parity_err = 0; data_out = 0.
  - Memory array is not reset directly.
- States:
  - INIT: each clk writes 0 to mem[cnt], then cnt++. After writing mem[DEPTH-1], go to IDLE and set ready=1 at that edge.
  - ready rises exactly DEPTH clocks after rst_n deasserts. ready=0 throughout INIT.
  - IDLE: ready=1; serves requests.
- Acceptance:
  - A request is accepted at a rising edge when cs=1 and ready=1.
  - cs while ready=0 is ignored with no side effects; no queuing.
- Write (rw=1), accepted with address < DEPTH: mem[address] <= data_in at that edge.
- Read (rw=0), accepted with address < DEPTH:
  - At the same edge: data_out <= mem[address], rd_valid <= 1.
  - Fixed 1-cycle latency.
  - A read one cycle after a write to the same address returns the new data.
- Out-of-range access (address >= DEPTH):
  - addr_err <= 1 for one cycle.
  - Write: dropped, memory unchanged.
  - Read: data_out <= 0, rd_valid <= 1.
- Flag timing:
  - rd_valid and addr_err are single-cycle pulses; they clear on the next edge with no accepted read or error.
  - data_out holds its last value when rd_valid=0.
- clear:
  - Sampled only in IDLE.
  - If a request is accepted on the same edge, the request executes at that edge; the state then goes to INIT with cnt=0, and ready drops for DEPTH cycles.
  - clear during INIT is ignored; the sequence does not restart.
- Back-to-back accepted requests every cycle are supported at full throughput.
- Reset asserted mid-INIT or mid-operation aborts immediately. INIT restarts from cnt=0 after release.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each stored word carries one extra even-parity bit, computed from data_in on write; INIT writes 0 with parity 0.
  - On an in-range accepted read, parity is recomputed from the stored data. parity_err <= 1 for one cycle, alongside rd_valid, on mismatch.
  - Out-of-range reads never set parity_err.
- Not defined: no parity storage; parity_err is tied to 0.

Test Plan:
- Reset release with DEPTH=64: ready=0 for 64 clocks, then 1. Reading addresses 0, 31, 63 returns 8'h00 with rd_valid=1 one cycle after each request.
- Write 8'hA5 to address 5, then read address 5 on the next cycle: data_out=8'hA5 and rd_valid=1 one cycle after the read.
- DEPTH=6, ADDR_WIDTH=6: write 8'hFF to address 6, then read address 6 gives data_out=0, rd_valid=1, addr_err=1. A read of address 5 still returns its prior value.
- Write 8'h3C to address 2 with clear=1 on the same edge: ready=0 for DEPTH cycles, after which reading address 2 returns 8'h00. cs pulses during the clear have no effect.
- Assert rst_n=0 at INIT cnt=20, release: ready rises exactly DEPTH clocks after release; all words read 0.
- With RAM_PARITY_EN defined: write 8'h01, force-flip one stored data bit via hierarchical access, read the word: parity_err=1 together with rd_valid. Without the macro, parity_err stays 0.

Source files
------------

// File: rtl/ram_sp_param_if.sv
// Request/response bundle for ram_sp_param.
// master drives requests, slave (the RAM) answers.
interface ram_sp_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  clear;
  logic                  cs;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  addr_err;
  logic                  parity_err;

  modport master (
    output clear, cs, rw, address, data_in,
    input  ready, data_out, rd_valid,
    input  addr_err, parity_err
  );

  modport slave (
    input  clear, cs, rw, address, data_in,
    output ready, data_out, rd_valid,
    output addr_err, parity_err
  );
endinterface

// File: rtl/ram_sp_param.sv
// Single-port RAM with clear sequencer and flags.
// Optional even parity per word: RAM_PARITY_EN.
module ram_sp_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input logic           clk,
  input logic           rst_n,
  ram_sp_param_if.slave bus
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = DATA_WIDTH + PW;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH))
  begin : g_bad_depth
    $error("ram_sp_param: DEPTH out of range");
  end

  typedef enum logic {INIT, IDLE} state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [MW-1:0]   mem [DEPTH];
  logic            accept;
  logic            in_range;
  logic            do_rd;
  logic            do_wr;
  logic [CW-1:0]   idx;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   rd_word;

  assign bus.ready = (state == IDLE);
  assign accept    = bus.cs & bus.ready;
  assign in_range  = {1'b0, bus.address} < LIMIT;
  assign idx       = bus.address[CW-1:0];
  assign do_rd     = accept & ~bus.rw;
  assign do_wr     = accept & bus.rw & in_range;
  assign rd_word   = mem[idx];

`ifdef RAM_PARITY_EN
  assign wr_word = {^bus.data_in, bus.data_in};
`else
  assign wr_word = bus.data_in;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      INIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      IDLE: begin
        // An accepted request still executes on the clear edge
        if (bus.clear) begin
          state_n = INIT;
          cnt_n   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (do_wr)
      mem[idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.addr_err <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.rd_valid <= do_rd;
      bus.addr_err <= accept & ~in_range;
      if (do_rd)
        bus.data_out <= in_range ?
          rd_word[DATA_WIDTH-1:0] : '0;
    end
  end

`ifdef RAM_PARITY_EN
  // Stored word incl. parity must XOR to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.parity_err <= 1'b0;
    else
      bus.parity_err <= do_rd & in_range & (^rd_word);
  end
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ram_sp_param.sv
// Vector table + scoreboard bench for ram_sp_param.
// Covers DEPTH=64 and DEPTH=6 instances.
module tb_ram_sp_param;
  typedef struct {
    bit         s6;
    logic       cs;
    logic       rw;
    logic       clr;
    logic [5:0] addr;
    logic [7:0] din;
    logic       rdy;
    logic       rv;
    logic       ae;
    logic       pe;
    logic [7:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_sp_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();
  ram_sp_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus6 ();

  ram_sp_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ram_sp_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(6)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6)
  );

  vec_t exp_q[$];
  vec_t tbl[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   step_no = 0;

  function automatic vec_t mk(
    bit s6, logic cs, logic rw, logic clr,
    logic [5:0] addr, logic [7:0] din,
    logic rdy, logic rv, logic ae, logic pe,
    logic [7:0] dout
  );
    vec_t v;
    v.s6 = s6; v.cs = cs; v.rw = rw; v.clr = clr;
    v.addr = addr; v.din = din; v.rdy = rdy;
    v.rv = rv; v.ae = ae; v.pe = pe; v.dout = dout;
    return v;
  endfunction

  task automatic check(
    input string name, input int act, input int req
  );
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus.cs = 0; bus.rw = 0; bus.clear = 0;
    bus.address = '0; bus.data_in = '0;
    bus6.cs = 0; bus6.rw = 0; bus6.clear = 0;
    bus6.address = '0; bus6.data_in = '0;
  endtask

  task automatic step(input vec_t v);
    vec_t  e;
    string t;
    idle_inputs();
    if (v.s6) begin
      bus6.cs = v.cs; bus6.rw = v.rw;
      bus6.clear = v.clr; bus6.address = v.addr;
      bus6.data_in = v.din;
    end else begin
      bus.cs = v.cs; bus.rw = v.rw;
      bus.clear = v.clr; bus.address = v.addr;
      bus.data_in = v.din;
    end
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    step_no++;
    e = exp_q.pop_front();
    t = $sformatf("s%0d", step_no);
    if (e.s6) begin
      check({t, "_ready6"}, int'(bus6.ready), int'(e.rdy));
      check({t, "_rv6"}, int'(bus6.rd_valid), int'(e.rv));
      check({t, "_ae6"}, int'(bus6.addr_err), int'(e.ae));
      check({t, "_pe6"}, int'(bus6.parity_err), int'(e.pe));
      check({t, "_dout6"}, int'(bus6.data_out), int'(e.dout));
    end else begin
      check({t, "_ready"}, int'(bus.ready), int'(e.rdy));
      check({t, "_rv"}, int'(bus.rd_valid), int'(e.rv));
      check({t, "_ae"}, int'(bus.addr_err), int'(e.ae));
      check({t, "_pe"}, int'(bus.parity_err), int'(e.pe));
      check({t, "_dout"}, int'(bus.data_out), int'(e.dout));
    end
    idle_inputs();
  endtask

  task automatic wait_ready(
    input bit s6, input string name, input int want
  );
    int n = 0;
    while (((s6 ? bus6.ready : bus.ready) !== 1'b1)
           && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(name, n, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    #1;
    check("rst_ready", int'(bus.ready), 0);
    check("rst_rv", int'(bus.rd_valid), 0);
    check("rst_ae", int'(bus.addr_err), 0);
    check("rst_pe", int'(bus.parity_err), 0);
    check("rst_dout", int'(bus.data_out), 0);
    check("rst_ready6", int'(bus6.ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    fork
      wait_ready(0, "init_latency64", 64);
      wait_ready(1, "init_latency6", 6);
    join

    // main function on the 64-word instance
    tbl.push_back(mk(0,1,0,0, 0,8'h00, 1,1,0,0,8'h00));
    tbl.push_back(mk(0,1,0,0,31,8'h00, 1,1,0,0,8'h00));
    tbl.push_back(mk(0,1,0,0,63,8'h00, 1,1,0,0,8'h00));
    tbl.push_back(mk(0,1,1,0, 5,8'hA5, 1,0,0,0,8'h00));
    tbl.push_back(mk(0,1,0,0, 5,8'h00, 1,1,0,0,8'hA5));
    tbl.push_back(mk(0,1,1,0,10,8'h5A, 1,0,0,0,8'hA5));
    tbl.push_back(mk(0,1,0,0,10,8'h00, 1,1,0,0,8'h5A));
    tbl.push_back(mk(0,0,0,0,10,8'h00, 1,0,0,0,8'h5A));
    tbl.push_back(mk(0,1,1,0,63,8'hC3, 1,0,0,0,8'h5A));
    tbl.push_back(mk(0,1,0,0,63,8'h00, 1,1,0,0,8'hC3));
    tbl.push_back(mk(0,1,0,0, 5,8'h00, 1,1,0,0,8'hA5));
    // 6-word instance: out-of-range handling
    tbl.push_back(mk(1,1,1,0, 5,8'h11, 1,0,0,0,8'h00));
    tbl.push_back(mk(1,1,1,0, 6,8'hFF, 1,0,1,0,8'h00));
    tbl.push_back(mk(1,1,0,0, 6,8'h00, 1,1,1,0,8'h00));
    tbl.push_back(mk(1,1,0,0, 5,8'h00, 1,1,0,0,8'h11));
    tbl.push_back(mk(1,0,0,0, 5,8'h00, 1,0,0,0,8'h11));
    tbl.push_back(mk(1,1,0,0,63,8'h00, 1,1,1,0,8'h00));
    tbl.push_back(mk(1,1,1,0, 0,8'h22, 1,0,0,0,8'h00));
    tbl.push_back(mk(1,1,0,0, 0,8'h00, 1,1,0,0,8'h22));
    tbl.push_back(mk(1,0,0,0, 0,8'h00, 1,0,0,0,8'h22));
    foreach (tbl[i]) step(tbl[i]);

    // write + clear on same edge, pulses during INIT
    step(mk(0,1,1,1, 2,8'h3C, 0,0,0,0,8'hA5));
    for (int i = 1; i <= 64; i++)
      step(mk(0, 1, i[0], (i == 10), 2, 8'hFF,
              (i == 64), 0, 0, 0, 8'hA5));
    step(mk(0,1,0,0, 2,8'h00, 1,1,0,0,8'h00));
    step(mk(0,1,1,0,40,8'h77, 1,0,0,0,8'h00));
    step(mk(0,1,0,0,40,8'h00, 1,1,0,0,8'h77));

    // reset in the middle of a clear sequence
    step(mk(0,0,0,1, 0,8'h00, 0,0,0,0,8'h77));
    for (int i = 0; i < 20; i++)
      step(mk(0,0,0,0, 0,8'h00, 0,0,0,0,8'h77));
    rst_n = 0;
    #1;
    check("midinit_rst_dout", int'(bus.data_out), 0);
    check("midinit_rst_ready", int'(bus.ready), 0);
    @(negedge clk);
    rst_n = 1;
    wait_ready(0, "reinit_latency64", 64);
    step(mk(0,1,0,0, 0,8'h00, 1,1,0,0,8'h00));
    step(mk(0,1,0,0,40,8'h00, 1,1,0,0,8'h00));
    step(mk(0,1,0,0,63,8'h00, 1,1,0,0,8'h00));

    step(mk(0,1,1,0, 7,8'h01, 1,0,0,0,8'h00));
`ifdef RAM_PARITY_EN
    dut.mem[7][0] = ~dut.mem[7][0];
    step(mk(0,1,0,0, 7,8'h00, 1,1,0,1,8'h00));
    step(mk(0,0,0,0, 7,8'h00, 1,0,0,0,8'h00));
`else
    step(mk(0,1,0,0, 7,8'h00, 1,1,0,0,8'h01));
    step(mk(0,0,0,0, 7,8'h00, 1,0,0,0,8'h01));
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
